// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: synchronizes and debounces pad inputs, latches edge flags, raises a maskable irq.
// All state advances on the falling clock edge to line up with the rest of the memory interface.
module gpio_in_conditioner #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_flags,
    output logic [WIDTH-1:0] fall_flags,
    input  logic [WIDTH-1:0] irq_en,
    input  logic             clr_write,
    input  logic [WIDTH-1:0] clr_mask,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, clr;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // A new event on the same edge as a clear keeps the flag set.
    assign clr    = {WIDTH{clr_write}} & clr_mask;
    assign rise_d = (stable_d & ~stable_q) | (rise_q & ~clr);
    assign fall_d = (~stable_d & stable_q) | (fall_q & ~clr);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= pins_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_out = stable_q;
    assign rise_flags = rise_q;
    assign fall_flags = fall_q;
    assign irq        = |((rise_q | fall_q) & irq_en);
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed checks of debounce latency, glitch rejection, flags and irq.
module tb_gpio_in_conditioner;
    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic [7:0] pins_in = 8'hFF;
    logic [7:0] stable_out, rise_flags, fall_flags;
    logic [7:0] irq_en = 8'h00;
    logic       clr_write = 1'b0;
    logic [7:0] clr_mask = 8'h00;
    logic       irq;
    int         n_cmp = 0;
    int         n_bad = 0;

    gpio_in_conditioner #(.WIDTH(8), .DB_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .pins_in(pins_in), .stable_out(stable_out),
        .rise_flags(rise_flags), .fall_flags(fall_flags), .irq_en(irq_en),
        .clr_write(clr_write), .clr_mask(clr_mask), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        clr_write = 1'b1;
        clr_mask  = 8'hFF;
        tick(1);
        clr_write = 1'b0;
        clr_mask  = 8'h00;
    endtask

    initial begin
        tick(3);
        chk("rst_stable", stable_out, 8'h00);
        chk("rst_rise", rise_flags, 8'h00);
        chk("rst_fall", fall_flags, 8'h00);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        tick(5);
        chk("rel_stable_early", stable_out, 8'h00);
        tick(1);
        chk("rel_stable", stable_out, 8'hFF);
        chk("rel_rise", rise_flags, 8'hFF);
        clear_all();
        chk("clr_rise", rise_flags, 8'h00);
        pins_in = 8'h00;
        tick(6);
        chk("all_low", stable_out, 8'h00);
        chk("all_low_fall", fall_flags, 8'hFF);
        clear_all();
        chk("clr_fall", fall_flags, 8'h00);
        // three-edge pulse is rejected
        pins_in = 8'h01;
        tick(3);
        pins_in = 8'h00;
        tick(8);
        chk("glitch_stable", stable_out, 8'h00);
        chk("glitch_rise", rise_flags, 8'h00);
        // four-edge pulse passes, six edges after first sample
        pins_in = 8'h01;
        tick(4);
        pins_in = 8'h00;
        tick(1);
        chk("pulse4_early", stable_out, 8'h00);
        tick(1);
        chk("pulse4_stable", stable_out, 8'h01);
        chk("pulse4_rise", rise_flags, 8'h01);
        tick(4);
        chk("pulse4_fallen", stable_out, 8'h00);
        chk("pulse4_fall", fall_flags, 8'h01);
        clear_all();
        // flag and irq with write-1-to-clear
        irq_en  = 8'h04;
        pins_in = 8'h04;
        tick(6);
        chk("p2_stable", stable_out, 8'h04);
        chk("p2_rise", rise_flags, 8'h04);
        chk("p2_irq", irq, 1'b1);
        clr_write = 1'b1;
        clr_mask  = 8'h04;
        tick(1);
        clr_write = 1'b0;
        clr_mask  = 8'h00;
        chk("p2_clr_rise", rise_flags, 8'h00);
        chk("p2_clr_irq", irq, 1'b0);
        // set beats clear on the same edge
        pins_in = 8'h0C;
        tick(6);
        chk("p3_rise", rise_flags, 8'h08);
        clear_all();
        pins_in = 8'h04;
        tick(5);
        chk("p3_pre_fall", stable_out, 8'h0C);
        clr_write = 1'b1;
        clr_mask  = 8'h08;
        tick(1);
        clr_write = 1'b0;
        clr_mask  = 8'h00;
        chk("p3_stable", stable_out, 8'h04);
        chk("set_beats_clr", fall_flags, 8'h08);
        clear_all();
        // masked flags still latch
        irq_en  = 8'h00;
        pins_in = 8'h24;
        tick(6);
        pins_in = 8'h04;
        tick(6);
        chk("mask_rise", rise_flags, 8'h20);
        chk("mask_fall", fall_flags, 8'h20);
        chk("mask_irq", irq, 1'b0);
        irq_en = 8'h20;
        #1;
        chk("unmask_irq", irq, 1'b1);
        irq_en = 8'h04;
        #1;
        chk("remask_irq", irq, 1'b0);
        clear_all();
        // reset mid-debounce discards partial count
        pins_in = 8'h06;
        tick(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_stable", stable_out, 8'h00);
        chk("mid_rst_rise", rise_flags, 8'h00);
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("mid_rel_early", stable_out, 8'h00);
        tick(1);
        chk("mid_rel_stable", stable_out, 8'h06);
        chk("mid_rel_rise", rise_flags, 8'h06);
        chk("mid_rel_irq", irq, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
